// File: rtl/video_driver.sv
// Raster timing generator and pixel-fetch master: h/v counters, early pixel
// request to the drawing block, and registered sync/de/rgb to the encoder.
module video_driver #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_LAST    = H_TOTAL - 11'd1;
  localparam logic [10:0] V_LAST    = V_TOTAL - 11'd1;
  localparam logic [10:0] HA        = H_SYNC + H_BACK;
  localparam logic [10:0] VA        = V_SYNC + V_BACK;
  localparam logic [10:0] H_END     = HA + H_DISP;
  localparam logic [10:0] V_END     = VA + V_DISP;
  localparam logic [10:0] H_REQ     = HA - 11'd1;
  localparam logic [10:0] H_REQ_END = H_END - 11'd1;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_active;
  logic        v_active;
  logic        de_decode;
  logic        h_req;

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Request window runs one clock ahead of the active window so the
  // drawing block's registered pixel_data lines up with de_decode.
  always_comb begin
    h_active   = (h_cnt >= HA) && (h_cnt < H_END);
    v_active   = (v_cnt >= VA) && (v_cnt < V_END);
    de_decode  = h_active && v_active;
    h_req      = (h_cnt >= H_REQ) && (h_cnt < H_REQ_END);
    data_req   = h_req && v_active;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (data_req) begin
      pixel_xpos = h_cnt - H_REQ;
      pixel_ypos = v_cnt - VA;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      video_hs    <= ~SYNC_POL;
      video_vs    <= ~SYNC_POL;
      video_de    <= 1'b0;
      video_rgb   <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_vs    <= (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_de    <= de_decode;
      video_rgb   <= de_decode ? pixel_data : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_video_driver.sv
// Directed bench for video_driver with a 14x7 raster (8x4 active).
module tb_video_driver;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] pixel_data = '0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        data_req, video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;
  logic        const_mode = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  always #5 clk = ~clk;

  video_driver #(
    .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd8), .H_FRONT(11'd2),
    .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd4), .V_FRONT(11'd1),
    .SYNC_POL(1'b1)
  ) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .frame_start(frame_start)
  );

  // Drawing block model: one clock of latency, pixel code = {y, x}.
  always_ff @(posedge clk)
    pixel_data <= const_mode ? 24'hFFFFFF : {2'd0, pixel_ypos, pixel_xpos};

  typedef struct {
    int          n;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        fs;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    n = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".hs"}, {31'd0, video_hs}, 32'd0);
    chk({tag, ".vs"}, {31'd0, video_vs}, 32'd0);
    chk({tag, ".de"}, {31'd0, video_de}, 32'd0);
    chk({tag, ".rgb"}, {8'd0, video_rgb}, 32'd0);
    chk({tag, ".fs"}, {31'd0, frame_start}, 32'd0);
    chk({tag, ".req"}, {31'd0, data_req}, 32'd0);
    chk({tag, ".xy"}, {10'd0, pixel_ypos, pixel_xpos}, 32'd0);
  endtask

  initial begin
    int fs_pos[$];
    int de_sum, hs_sum, vs_sum, req_sum, de_rise, run, run_err, seq_err, align_err, rgb_err;
    logic [10:0] exp_x;
    logic p_hs, p_vs, p_de;

    //          n   req x     y     hs vs de rgb       fs
    tbl[0]  = '{0,  0, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[1]  = '{1,  0, 11'd0, 11'd0, 1, 1, 0, 24'h0,    1};
    tbl[2]  = '{2,  0, 11'd0, 11'd0, 1, 1, 0, 24'h0,    0};
    tbl[3]  = '{3,  0, 11'd0, 11'd0, 0, 1, 0, 24'h0,    0};
    tbl[4]  = '{15, 0, 11'd0, 11'd0, 1, 0, 0, 24'h0,    0};
    tbl[5]  = '{31, 1, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[6]  = '{32, 1, 11'd1, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[7]  = '{33, 1, 11'd2, 11'd0, 0, 0, 1, 24'h0,    0};
    tbl[8]  = '{34, 1, 11'd3, 11'd0, 0, 0, 1, 24'h1,    0};
    tbl[9]  = '{38, 1, 11'd7, 11'd0, 0, 0, 1, 24'h5,    0};
    tbl[10] = '{39, 0, 11'd0, 11'd0, 0, 0, 1, 24'h6,    0};
    tbl[11] = '{40, 0, 11'd0, 11'd0, 0, 0, 1, 24'h7,    0};
    tbl[12] = '{41, 0, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[13] = '{42, 0, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[14] = '{43, 0, 11'd0, 11'd0, 1, 0, 0, 24'h0,    0};
    tbl[15] = '{64, 1, 11'd5, 11'd2, 0, 0, 1, 24'h1003, 0};
    tbl[16] = '{79, 1, 11'd6, 11'd3, 0, 0, 1, 24'h1804, 0};
    tbl[17] = '{85, 0, 11'd0, 11'd0, 1, 0, 0, 24'h0,    0};
    tbl[18] = '{87, 0, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[19] = '{98, 0, 11'd0, 11'd0, 0, 0, 0, 24'h0,    0};
    tbl[20] = '{99, 0, 11'd0, 11'd0, 1, 1, 0, 24'h0,    1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    release_rst();

    foreach (tbl[i]) begin
      while (n < tbl[i].n) step();
      chk($sformatf("v%0d.req", tbl[i].n), {31'd0, data_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d.x", tbl[i].n), {21'd0, pixel_xpos}, {21'd0, tbl[i].x});
      chk($sformatf("v%0d.y", tbl[i].n), {21'd0, pixel_ypos}, {21'd0, tbl[i].y});
      chk($sformatf("v%0d.hs", tbl[i].n), {31'd0, video_hs}, {31'd0, tbl[i].hs});
      chk($sformatf("v%0d.vs", tbl[i].n), {31'd0, video_vs}, {31'd0, tbl[i].vs});
      chk($sformatf("v%0d.de", tbl[i].n), {31'd0, video_de}, {31'd0, tbl[i].de});
      chk($sformatf("v%0d.rgb", tbl[i].n), {8'd0, video_rgb}, {8'd0, tbl[i].rgb});
      chk($sformatf("v%0d.fs", tbl[i].n), {31'd0, frame_start}, {31'd0, tbl[i].fs});
    end

    // One full frame (n=99..196): sync widths, de runs, request sequence.
    de_sum = 0; hs_sum = 0; vs_sum = 0; req_sum = 0; de_rise = 0;
    run = 0; run_err = 0; seq_err = 0; align_err = 0; exp_x = '0;
    p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
    for (int k = 0; k < 98; k++) begin
      if (k > 0) step();
      de_sum += int'(video_de);
      hs_sum += int'(video_hs);
      vs_sum += int'(video_vs);
      req_sum += int'(data_req);
      if (video_de && !p_de) de_rise++;
      if (video_de) run++;
      else begin
        if (p_de && run != 8) run_err++;
        run = 0;
      end
      if (data_req) begin
        if (pixel_xpos != exp_x) seq_err++;
        exp_x = (exp_x == 11'd7) ? '0 : exp_x + 11'd1;
      end else if (pixel_xpos != '0 || pixel_ypos != '0) seq_err++;
      if (video_vs != p_vs && !(video_hs && !p_hs)) align_err++;
      p_hs = video_hs; p_vs = video_vs; p_de = video_de;
    end
    chk("frame.de_clks", de_sum, 32);
    chk("frame.de_lines", de_rise, 4);
    chk("frame.de_run8", run_err, 0);
    chk("frame.hs_clks", hs_sum, 14);
    chk("frame.vs_clks", vs_sum, 14);
    chk("frame.req_clks", req_sum, 32);
    chk("frame.xpos_seq", seq_err, 0);
    chk("frame.vs_hs_align", align_err, 0);

    // Constant white pixel data: must be blanked whenever de is low.
    const_mode = 1'b1;
    rgb_err = 0;
    for (int k = 0; k < 196; k++) begin
      step();
      if (!video_de && video_rgb != '0) rgb_err++;
      if (k >= 98 && video_de && video_rgb != 24'hFFFFFF) rgb_err++;
    end
    chk("white.blanking", rgb_err, 0);
    const_mode = 1'b0;

    // Frame-start spacing over the span already run plus a little more.
    release_rst_check: begin
      for (int k = 0; k < 4; k++) begin
        while (n % 98 != 1) step();
        if (frame_start) fs_pos.push_back(n);
        step();
      end
      chk("fs.count", fs_pos.size(), 4);
      for (int k = 1; k < fs_pos.size(); k++)
        chk($sformatf("fs.period%0d", k), fs_pos[k] - fs_pos[k-1], 98);
    end

    // Mid-line asynchronous reset at h_cnt=6, v_cnt=3.
    while (n % 98 != 48) step();
    chk("pre_rst.req", {31'd0, data_req}, 32'd1);
    chk("pre_rst.de", {31'd0, video_de}, 32'd1);
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk_reset_vals("held_rst");
    release_rst();
    chk_reset_vals("post_rel");
    de_sum = 0;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 1) begin
        chk("restart.fs", {31'd0, frame_start}, 32'd1);
        chk("restart.hs", {31'd0, video_hs}, 32'd1);
        chk("restart.vs", {31'd0, video_vs}, 32'd1);
      end else if (frame_start) begin
        chk("restart.fs_extra", {31'd0, frame_start}, 32'd0);
      end
      if (k < 33) de_sum += int'(video_de);
    end
    chk("restart.no_partial", de_sum, 0);
    chk("restart.first_de", {31'd0, video_de}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
